// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: single-entry buffer feeding the ALU, with EX/MEM and MEM/WB forwarding and load-use stall.
// Latency 1 cycle; in_ready_o drops while the entry is held (consumer stalled or load-use hazard).
package riscv_pkg;
    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_OR  = 2'd1,
        ALU_ADD = 2'd2,
        ALU_SUB = 2'd3
    } alu_op_t;
endpackage

module ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  alu_op_t         in_op_i,
    input  logic [REGW-1:0] in_rs1_i,
    input  logic [REGW-1:0] in_rs2_i,
    input  logic [XLEN-1:0] in_rs1_data_i,
    input  logic [XLEN-1:0] in_rs2_data_i,
    input  logic [XLEN-1:0] in_imm_i,
    input  logic            in_use_imm_i,
    input  logic [REGW-1:0] in_rd_i,
    input  logic            in_we_i,
    input  logic [REGW-1:0] mem_rd_i,
    input  logic            mem_we_i,
    input  logic            mem_is_load_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic [REGW-1:0] wb_rd_i,
    input  logic            wb_we_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output alu_op_t         op_o,
    output logic [XLEN-1:0] A_o,
    output logic [XLEN-1:0] B_o,
    output logic [REGW-1:0] rd_o,
    output logic            we_o
);

    typedef struct packed {
        alu_op_t         op;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [REGW-1:0] rd;
        logic            we;
    } entry_t;

    entry_t entry_q;
    logic   valid_q;
    logic   hazard;
    logic   capture;
    logic   drain;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // EX/MEM has priority over MEM/WB; x0 always reads its stored (zero) value.
    function automatic logic [XLEN-1:0] fwd(
        input logic [REGW-1:0] rs,
        input logic [XLEN-1:0] stored
    );
        if (rs != '0 && mem_we_i && mem_rd_i == rs)
            return mem_data_i;
        else if (rs != '0 && wb_we_i && wb_rd_i == rs)
            return wb_data_i;
        else
            return stored;
    endfunction

    always_comb begin
        rs1_fwd = fwd(entry_q.rs1, entry_q.rs1_data);
        rs2_fwd = fwd(entry_q.rs2, entry_q.rs2_data);
    end

    // A load in EX/MEM has no data yet, so a dependent entry must wait for it to reach WB.
    always_comb begin
        hazard = valid_q && mem_we_i && mem_is_load_i && (mem_rd_i != '0) &&
                 ((mem_rd_i == entry_q.rs1) ||
                  (!entry_q.use_imm && (mem_rd_i == entry_q.rs2)));
    end

    assign out_valid_o = valid_q && !hazard;
    assign in_ready_o  = !valid_q || (out_valid_o && out_ready_i);
    assign capture     = in_valid_i && in_ready_o && !flush_i;
    assign drain       = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            entry_q <= '{op: ALU_ADD, rs1: '0, rs2: '0, rs1_data: '0, rs2_data: '0,
                         imm: '0, use_imm: 1'b0, rd: '0, we: 1'b0};
        end else begin
            if (flush_i)
                valid_q <= 1'b0;
            else if (capture)
                valid_q <= 1'b1;
            else if (drain)
                valid_q <= 1'b0;

            if (capture) begin
                entry_q.op       <= in_op_i;
                entry_q.rs1      <= in_rs1_i;
                entry_q.rs2      <= in_rs2_i;
                entry_q.rs1_data <= in_rs1_data_i;
                entry_q.rs2_data <= in_rs2_data_i;
                entry_q.imm      <= in_imm_i;
                entry_q.use_imm  <= in_use_imm_i;
                entry_q.rd       <= in_rd_i;
                entry_q.we       <= in_we_i;
            end
        end
    end

    assign op_o = entry_q.op;
    assign A_o  = rs1_fwd;
    assign B_o  = entry_q.use_imm ? entry_q.imm : rs2_fwd;
    assign rd_o = entry_q.rd;
    assign we_o = entry_q.we;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for forwarding/hazard cases plus hand-written sequences.
module tb_ex_operand_stage;
    import riscv_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    alu_op_t         in_op_i;
    logic [4:0]      in_rs1_i, in_rs2_i, in_rd_i;
    logic [31:0]     in_rs1_data_i, in_rs2_data_i, in_imm_i;
    logic            in_use_imm_i, in_we_i;
    logic [4:0]      mem_rd_i, wb_rd_i;
    logic            mem_we_i, mem_is_load_i, wb_we_i;
    logic [31:0]     mem_data_i, wb_data_i;
    logic            out_valid_o, out_ready_i;
    alu_op_t         op_o;
    logic [31:0]     A_o, B_o;
    logic [4:0]      rd_o;
    logic            we_o;

    int total = 0;
    int bad   = 0;

    ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i),
        .in_imm_i(in_imm_i), .in_use_imm_i(in_use_imm_i),
        .in_rd_i(in_rd_i), .in_we_i(in_we_i),
        .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i), .mem_is_load_i(mem_is_load_i),
        .mem_data_i(mem_data_i), .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_data_i(wb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .op_o(op_o), .A_o(A_o), .B_o(B_o), .rd_o(rd_o), .we_o(we_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        alu_op_t     op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  mrd;
        logic        mwe;
        logic        mld;
        logic [31:0] mdat;
        logic [4:0]  wrd;
        logic        wwe;
        logic [31:0] wdat;
        logic        exp_vld;
        logic        exp_rdy;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_bypass();
        mem_rd_i = '0; mem_we_i = 1'b0; mem_is_load_i = 1'b0; mem_data_i = '0;
        wb_rd_i = '0;  wb_we_i = 1'b0;  wb_data_i = '0;
    endtask

    task automatic drive_in(input alu_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic use_imm, input logic [4:0] rd, input logic we);
        in_valid_i = 1'b1; in_op_i = op; in_rs1_i = rs1; in_rs2_i = rs2;
        in_rs1_data_i = d1; in_rs2_data_i = d2; in_imm_i = imm;
        in_use_imm_i = use_imm; in_rd_i = rd; in_we_i = we;
    endtask

    initial begin
        //          op       rs1 rs2 d1        d2        imm            ui  rd  we  mrd mwe mld mdat      wrd wwe wdat      vld rdy a         b
        vecs[0] = '{ALU_ADD, 5'd1, 5'd2, 32'h5,  32'h7,  32'h0,         1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h5,  32'h7};
        vecs[1] = '{ALU_ADD, 5'd3, 5'd2, 32'h11, 32'h7,  32'h0,         1'b0, 5'd11, 1'b1, 5'd3, 1'b1, 1'b0, 32'hAA, 5'd3, 1'b1, 32'hBB, 1'b1, 1'b1, 32'hAA, 32'h7};
        vecs[2] = '{ALU_ADD, 5'd3, 5'd2, 32'h11, 32'h7,  32'h0,         1'b0, 5'd11, 1'b1, 5'd3, 1'b0, 1'b0, 32'hAA, 5'd3, 1'b1, 32'hBB, 1'b1, 1'b1, 32'hBB, 32'h7};
        vecs[3] = '{ALU_OR,  5'd0, 5'd0, 32'h0,  32'h0,  32'hFFFFFFF0,  1'b1, 5'd12, 1'b0, 5'd0, 1'b1, 1'b0, 32'hFF, 5'd0, 1'b1, 32'hEE, 1'b1, 1'b1, 32'h0,  32'hFFFFFFF0};
        vecs[4] = '{ALU_AND, 5'd5, 5'd4, 32'h9,  32'h3,  32'h10,        1'b1, 5'd13, 1'b1, 5'd4, 1'b1, 1'b1, 32'h99, 5'd0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h9,  32'h10};
        vecs[5] = '{ALU_SUB, 5'd6, 5'd1, 32'h21, 32'h22, 32'h0,         1'b0, 5'd14, 1'b1, 5'd6, 1'b1, 1'b1, 32'h33, 5'd0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h33, 32'h22};
        vecs[6] = '{ALU_ADD, 5'd1, 5'd7, 32'h23, 32'h24, 32'h0,         1'b0, 5'd15, 1'b1, 5'd7, 1'b1, 1'b1, 32'h44, 5'd0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h23, 32'h44};
        vecs[7] = '{ALU_ADD, 5'd2, 5'd8, 32'h25, 32'h26, 32'h0,         1'b0, 5'd16, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,  5'd8, 1'b1, 32'h77, 1'b1, 1'b1, 32'h25, 32'h77};
        vecs[8] = '{ALU_ADD, 5'd3, 5'd4, 32'h27, 32'h28, 32'h0,         1'b0, 5'd17, 1'b1, 5'd3, 1'b0, 1'b0, 32'h55, 5'd4, 1'b0, 32'h66, 1'b1, 1'b1, 32'h27, 32'h28};
        vecs[9] = '{ALU_SUB, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,         1'b0, 5'd18, 1'b1, 5'd0, 1'b1, 1'b0, 32'h11, 5'd0, 1'b1, 32'h55, 1'b1, 1'b1, 32'h0,  32'h0};

        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
        in_valid_i = 1'b0; in_op_i = ALU_AND; in_rs1_i = '0; in_rs2_i = '0;
        in_rs1_data_i = '0; in_rs2_data_i = '0; in_imm_i = '0;
        in_use_imm_i = 1'b0; in_rd_i = '0; in_we_i = 1'b0;
        clear_bypass();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("reset_valid", 32'(out_valid_o), 32'h0);
        chk("reset_ready", 32'(in_ready_o), 32'h1);
        chk("reset_A", A_o, 32'h0);
        chk("reset_B", B_o, 32'h0);
        chk("reset_op", 32'(op_o), 32'(ALU_ADD));
        chk("reset_rd", 32'(rd_o), 32'h0);
        chk("reset_we", 32'(we_o), 32'h0);

        // Table: capture one entry, then apply the bypass state and check the presented operands.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            clear_bypass();
            drive_in(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2,
                     vecs[i].imm, vecs[i].use_imm, vecs[i].rd, vecs[i].we);
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
            mem_rd_i = vecs[i].mrd; mem_we_i = vecs[i].mwe; mem_is_load_i = vecs[i].mld;
            mem_data_i = vecs[i].mdat;
            wb_rd_i = vecs[i].wrd; wb_we_i = vecs[i].wwe; wb_data_i = vecs[i].wdat;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid_o), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready_o), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_A", i), A_o, vecs[i].exp_a);
            chk($sformatf("vec%0d_B", i), B_o, vecs[i].exp_b);
            chk($sformatf("vec%0d_op", i), 32'(op_o), 32'(vecs[i].op));
            chk($sformatf("vec%0d_rd", i), 32'(rd_o), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_we", i), 32'(we_o), 32'(vecs[i].we));
        end

        // Drain with nothing new arriving empties the stage.
        @(negedge clk_i);
        clear_bypass();
        @(posedge clk_i);
        #1;
        chk("drain_valid", 32'(out_valid_o), 32'h0);
        chk("drain_ready", 32'(in_ready_o), 32'h1);

        // Back-to-back captures at one per cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            drive_in(ALU_ADD, 5'd1, 5'd2, 32'(16 * (i + 1)), 32'(i), 32'h0, 1'b0, 5'(20 + i), 1'b1);
            @(posedge clk_i);
            #1;
            chk($sformatf("b2b%0d_valid", i), 32'(out_valid_o), 32'h1);
            chk($sformatf("b2b%0d_ready", i), 32'(in_ready_o), 32'h1);
            chk($sformatf("b2b%0d_A", i), A_o, 32'(16 * (i + 1)));
            chk($sformatf("b2b%0d_rd", i), 32'(rd_o), 32'(20 + i));
        end

        // Load-use stall: entry held, new input refused, then WB data releases it.
        @(negedge clk_i);
        drive_in(ALU_ADD, 5'd9, 5'd0, 32'h1, 32'h0, 32'h0, 1'b0, 5'd25, 1'b1);
        @(posedge clk_i);
        #1;
        mem_rd_i = 5'd9; mem_we_i = 1'b1; mem_is_load_i = 1'b1; mem_data_i = 32'hDEAD;
        drive_in(ALU_SUB, 5'd1, 5'd1, 32'hBAD, 32'hBAD, 32'h0, 1'b0, 5'd26, 1'b0);
        #1;
        chk("stall_valid", 32'(out_valid_o), 32'h0);
        chk("stall_ready", 32'(in_ready_o), 32'h0);
        @(posedge clk_i);
        #1;
        chk("stall_held_rd", 32'(rd_o), 32'd25);
        chk("stall_held_valid", 32'(out_valid_o), 32'h0);
        in_valid_i = 1'b0;
        clear_bypass();
        wb_rd_i = 5'd9; wb_we_i = 1'b1; wb_data_i = 32'h42;
        #1;
        chk("release_valid", 32'(out_valid_o), 32'h1);
        chk("release_A", A_o, 32'h42);
        @(negedge clk_i);
        clear_bypass();
        @(posedge clk_i);
        #1;

        // Flush while full and stalled by the consumer: nothing captured, stage empties.
        out_ready_i = 1'b0;
        @(negedge clk_i);
        drive_in(ALU_OR, 5'd10, 5'd0, 32'h3, 32'h0, 32'h0, 1'b0, 5'd27, 1'b1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        #1;
        chk("full_valid", 32'(out_valid_o), 32'h1);
        chk("full_ready", 32'(in_ready_o), 32'h0);
        @(negedge clk_i);
        flush_i = 1'b1;
        drive_in(ALU_AND, 5'd11, 5'd0, 32'h4, 32'h0, 32'h0, 1'b0, 5'd28, 1'b1);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        #1;
        chk("flush_valid", 32'(out_valid_o), 32'h0);
        chk("flush_ready", 32'(in_ready_o), 32'h1);

        // Flush while empty with input offered: still nothing captured.
        @(negedge clk_i);
        flush_i = 1'b1;
        drive_in(ALU_AND, 5'd12, 5'd0, 32'h6, 32'h0, 32'h0, 1'b0, 5'd29, 1'b1);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        #1;
        chk("flush_empty_valid", 32'(out_valid_o), 32'h0);
        chk("flush_empty_rd", 32'(rd_o), 32'd27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
